// File: rtl/fir_xifu_mem_resp.sv
// X-IF memory request/response unit: issues aligned requests on a simple req/gnt/rvalid bus,
// answers misaligned ones locally, and returns results strictly in acceptance order.
module fir_xifu_mem_resp #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_valid_i,
  output logic                mem_ready_o,
  input  logic [ID_WIDTH-1:0] mem_id_i,
  input  logic [31:0]         mem_addr_i,
  input  logic                mem_we_i,
  input  logic [3:0]          mem_be_i,
  input  logic [31:0]         mem_wdata_i,
  output logic                mem_result_valid_o,
  output logic [ID_WIDTH-1:0] mem_result_id_o,
  output logic [31:0]         mem_result_rdata_o,
  output logic                mem_result_err_o,
  output logic                data_req_o,
  output logic [31:0]         data_addr_o,
  output logic                data_we_o,
  output logic [3:0]          data_be_o,
  output logic [31:0]         data_wdata_o,
  input  logic                data_gnt_i,
  input  logic                data_rvalid_i,
  input  logic [31:0]         data_rdata_i,
  input  logic                data_err_i
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t state_q, state_d;

  logic [ID_WIDTH-1:0] fifo_id   [DEPTH];
  logic                fifo_lerr [DEPTH];
  logic                fifo_we   [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;

  logic full, empty, misaligned, accept, pop, head_lerr, head_we;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  assign misaligned = ((mem_be_i == 4'b1111) && (mem_addr_i[1:0] != 2'b00)) ||
                      (((mem_be_i == 4'b0011) || (mem_be_i == 4'b1100)) && mem_addr_i[0]);

  assign head_lerr = fifo_lerr[rd_ptr];
  assign head_we   = fifo_we[rd_ptr];

  // A local-error head retires on its own; bus responses only retire a bus-backed head.
  assign pop    = !empty && (head_lerr || data_rvalid_i);
  assign accept = mem_valid_i && mem_ready_o;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    mem_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        mem_ready_o = !full && (!misaligned || empty);
        if (mem_valid_i && mem_ready_o && !misaligned) state_d = REQ;
      end
      REQ:     if (data_gnt_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign data_req_o = (state_q == REQ);

  // Bus request fields are captured once at accept and held stable until the grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_addr_o  <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
    end else if (accept && !misaligned) begin
      data_addr_o  <= mem_addr_i;
      data_we_o    <= mem_we_i;
      data_be_o    <= mem_be_i;
      data_wdata_o <= mem_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: FIFO storage has no reset; an entry is only read once count says it was written.
    if (accept) begin
      fifo_id[wr_ptr]   <= mem_id_i;
      fifo_lerr[wr_ptr] <= misaligned;
      fifo_we[wr_ptr]   <= mem_we_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_result_valid_o <= 1'b0;
      mem_result_id_o    <= '0;
      mem_result_rdata_o <= '0;
      mem_result_err_o   <= 1'b0;
    end else begin
      mem_result_valid_o <= pop;
      if (pop) begin
        mem_result_id_o    <= fifo_id[rd_ptr];
        mem_result_err_o   <= head_lerr || data_err_i;
        mem_result_rdata_o <= (head_lerr || data_err_i || head_we) ? 32'h0 : data_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_fir_xifu_mem_resp.sv
// Self-checking bench for fir_xifu_mem_resp: directed scenarios plus a randomized run
// checked against an in-order transaction model.
module tb_fir_xifu_mem_resp;

  localparam int DEPTH    = 4;
  localparam int ID_WIDTH = 4;
  localparam int MAXT     = 1024;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                mem_valid_i, mem_ready_o;
  logic [ID_WIDTH-1:0] mem_id_i;
  logic [31:0]         mem_addr_i;
  logic                mem_we_i;
  logic [3:0]          mem_be_i;
  logic [31:0]         mem_wdata_i;
  logic                mem_result_valid_o;
  logic [ID_WIDTH-1:0] mem_result_id_o;
  logic [31:0]         mem_result_rdata_o;
  logic                mem_result_err_o;
  logic                data_req_o;
  logic [31:0]         data_addr_o;
  logic                data_we_o;
  logic [3:0]          data_be_o;
  logic [31:0]         data_wdata_o;
  logic                data_gnt_i, data_rvalid_i;
  logic [31:0]         data_rdata_i;
  logic                data_err_i;

  int errors = 0;
  int checks = 0;

  // Transaction model: one record per accepted request, in acceptance order.
  logic [ID_WIDTH-1:0] e_id     [MAXT];
  logic                e_we     [MAXT];
  logic                e_err    [MAXT];
  logic [31:0]         e_rdata  [MAXT];
  bit                  e_filled [MAXT];

  fir_xifu_mem_resp #(.DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_id_i(mem_id_i),
    .mem_addr_i(mem_addr_i), .mem_we_i(mem_we_i), .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i),
    .mem_result_valid_o(mem_result_valid_o), .mem_result_id_o(mem_result_id_o),
    .mem_result_rdata_o(mem_result_rdata_o), .mem_result_err_o(mem_result_err_o),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    mem_valid_i = 1'b0; mem_id_i = '0; mem_addr_i = '0; mem_we_i = 1'b0; mem_be_i = '0; mem_wdata_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
  endtask

  task automatic present(input logic [ID_WIDTH-1:0] id, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata);
    mem_valid_i = 1'b1; mem_id_i = id; mem_addr_i = addr; mem_we_i = we; mem_be_i = be; mem_wdata_i = wdata;
  endtask

  function automatic bit model_misaligned(input logic [31:0] addr, input logic [3:0] be);
    if (be == 4'b1111) return addr[1:0] != 2'b00;
    if (be == 4'b0011 || be == 4'b1100) return addr[0];
    return 1'b0;
  endfunction

  task automatic test_reset();
    idle();
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", data_req_o); end
    checks++; if (mem_result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", mem_result_valid_o); end
    checks++; if ({mem_result_err_o, mem_result_id_o, mem_result_rdata_o} !== '0) begin errors++;
      $display("FAIL reset_result: err=%b id=%h rdata=%h want 0", mem_result_err_o, mem_result_id_o, mem_result_rdata_o); end
    checks++; if ({data_addr_o, data_we_o, data_be_o, data_wdata_o} !== '0) begin errors++;
      $display("FAIL reset_bus: addr=%h we=%b be=%h wdata=%h want 0", data_addr_o, data_we_o, data_be_o, data_wdata_o); end
    checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", mem_ready_o); end
  endtask

  task automatic test_aligned_load();
    present(3, 32'h100, 1'b0, 4'hF, 32'h0); #1;
    checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1", mem_ready_o); end
    tick(); idle();
    checks++; if ({data_req_o, data_addr_o, data_we_o, data_be_o} !== {1'b1, 32'h100, 1'b0, 4'hF}) begin errors++;
      $display("FAIL load_req: req=%b addr=%h we=%b be=%h want 1/100/0/f", data_req_o, data_addr_o, data_we_o, data_be_o); end
    data_gnt_i = 1'b1; tick(); data_gnt_i = 1'b0;
    checks++; if ({data_req_o, mem_result_valid_o} !== 2'b00) begin errors++;
      $display("FAIL load_after_gnt: req=%b valid=%b want 0/0", data_req_o, mem_result_valid_o); end
    data_rvalid_i = 1'b1; data_rdata_i = 32'hDEADBEEF; tick(); idle();
    checks++; if ({mem_result_valid_o, mem_result_id_o, mem_result_err_o, mem_result_rdata_o} !== {1'b1, 4'd3, 1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL load_result: valid=%b id=%h err=%b rdata=%h want 1/3/0/deadbeef",
                         mem_result_valid_o, mem_result_id_o, mem_result_err_o, mem_result_rdata_o); end
    tick();
    checks++; if ({mem_result_valid_o, mem_result_id_o, mem_result_rdata_o} !== {1'b0, 4'd3, 32'hDEADBEEF}) begin
      errors++; $display("FAIL load_hold: valid=%b id=%h rdata=%h want 0/3/deadbeef",
                         mem_result_valid_o, mem_result_id_o, mem_result_rdata_o); end
  endtask

  task automatic test_misaligned();
    present(5, 32'h102, 1'b0, 4'hF, 32'h0); #1;
    checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL mis_ready: got %b want 1", mem_ready_o); end
    tick(); idle();
    checks++; if ({data_req_o, mem_result_valid_o} !== 2'b00) begin errors++;
      $display("FAIL mis_no_req: req=%b valid=%b want 0/0", data_req_o, mem_result_valid_o); end
    tick();
    checks++; if ({mem_result_valid_o, mem_result_id_o, mem_result_err_o, mem_result_rdata_o} !== {1'b1, 4'd5, 1'b1, 32'h0}) begin
      errors++; $display("FAIL mis_result: valid=%b id=%h err=%b rdata=%h want 1/5/1/0",
                         mem_result_valid_o, mem_result_id_o, mem_result_err_o, mem_result_rdata_o); end
    tick();
    // Same misaligned request while one aligned load is outstanding.
    present(6, 32'h200, 1'b0, 4'hF, 32'h0); tick();
    present(7, 32'h102, 1'b0, 4'hF, 32'h0); data_gnt_i = 1'b1; #1;
    checks++; if (mem_ready_o !== 1'b0) begin errors++; $display("FAIL mis_block_req: got %b want 0", mem_ready_o); end
    tick(); data_gnt_i = 1'b0; #1;
    checks++; if (mem_ready_o !== 1'b0) begin errors++; $display("FAIL mis_block_idle: got %b want 0", mem_ready_o); end
    tick(); data_rvalid_i = 1'b1; data_rdata_i = 32'h11223344; #1;
    checks++; if (mem_ready_o !== 1'b0) begin errors++; $display("FAIL mis_block_pop: got %b want 0", mem_ready_o); end
    tick(); data_rvalid_i = 1'b0;
    checks++; if ({mem_result_valid_o, mem_result_id_o, mem_result_rdata_o} !== {1'b1, 4'd6, 32'h11223344}) begin
      errors++; $display("FAIL mis_prev_result: valid=%b id=%h rdata=%h want 1/6/11223344",
                         mem_result_valid_o, mem_result_id_o, mem_result_rdata_o); end
    #1;
    checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL mis_unblock: got %b want 1", mem_ready_o); end
    tick(); idle();
    checks++; if ({data_req_o, mem_result_valid_o} !== 2'b00) begin errors++;
      $display("FAIL mis2_no_req: req=%b valid=%b want 0/0", data_req_o, mem_result_valid_o); end
    tick();
    checks++; if ({mem_result_valid_o, mem_result_id_o, mem_result_err_o, mem_result_rdata_o} !== {1'b1, 4'd7, 1'b1, 32'h0}) begin
      errors++; $display("FAIL mis2_result: valid=%b id=%h err=%b rdata=%h want 1/7/1/0",
                         mem_result_valid_o, mem_result_id_o, mem_result_err_o, mem_result_rdata_o); end
    tick();
  endtask

  task automatic test_grant_stall();
    present(2, 32'h340, 1'b1, 4'hF, 32'hCAFEF00D); tick(); idle();
    for (int i = 0; i < 6; i++) begin
      checks++; if ({data_req_o, data_addr_o, data_wdata_o, mem_ready_o} !== {1'b1, 32'h340, 32'hCAFEF00D, 1'b0}) begin
        errors++; $display("FAIL stall_cycle%0d: req=%b addr=%h wdata=%h ready=%b want 1/340/cafef00d/0",
                           i, data_req_o, data_addr_o, data_wdata_o, mem_ready_o); end
      data_gnt_i = (i == 5);
      tick();
    end
    data_gnt_i = 1'b0;
    checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL stall_release: req=%b want 0", data_req_o); end
    data_rvalid_i = 1'b1; data_rdata_i = 32'h55; tick(); idle();
    checks++; if ({mem_result_valid_o, mem_result_id_o, mem_result_err_o, mem_result_rdata_o} !== {1'b1, 4'd2, 1'b0, 32'h0}) begin
      errors++; $display("FAIL stall_result: valid=%b id=%h err=%b rdata=%h want 1/2/0/0",
                         mem_result_valid_o, mem_result_id_o, mem_result_err_o, mem_result_rdata_o); end
    tick();
  endtask

  task automatic check_wrap_result(input int k, input string name);
    checks++; if ({mem_result_valid_o, mem_result_id_o, mem_result_err_o, mem_result_rdata_o} !== {1'b1, ID_WIDTH'(k), 1'b0, 32'h0}) begin
      errors++; $display("FAIL %s: valid=%b id=%h err=%b rdata=%h want 1/%0h/0/0", name,
                         mem_result_valid_o, mem_result_id_o, mem_result_err_o, mem_result_rdata_o, k); end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 4; i++) begin
      present(ID_WIDTH'(i), 32'h1000 + 32'(4 * i), 1'b1, 4'hF, 32'(i)); #1;
      checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL wrap_fill%0d: ready=%b want 1", i, mem_ready_o); end
      tick(); idle(); data_gnt_i = 1'b1;
      tick(); idle();
    end
    present(4, 32'h1010, 1'b1, 4'hF, 32'h4);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (mem_ready_o !== 1'b0) begin errors++; $display("FAIL wrap_full%0d: ready=%b want 0", i, mem_ready_o); end
      tick();
    end
    data_rvalid_i = 1'b1; data_rdata_i = $urandom | 32'h1; #1;
    checks++; if (mem_ready_o !== 1'b0) begin errors++; $display("FAIL wrap_full_pop: ready=%b want 0", mem_ready_o); end
    tick();
    check_wrap_result(0, "wrap_res0"); #1;
    checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL wrap_pushpop: ready=%b want 1", mem_ready_o); end
    tick();
    check_wrap_result(1, "wrap_res1");
    checks++; if ({data_req_o, data_addr_o} !== {1'b1, 32'h1010}) begin errors++;
      $display("FAIL wrap_req4: req=%b addr=%h want 1/1010", data_req_o, data_addr_o); end
    present(5, 32'h1014, 1'b1, 4'hF, 32'h5); data_gnt_i = 1'b1; tick();
    check_wrap_result(2, "wrap_res2");
    data_gnt_i = 1'b0; #1;
    checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL wrap_accept5: ready=%b want 1", mem_ready_o); end
    tick(); mem_valid_i = 1'b0;
    check_wrap_result(3, "wrap_res3");
    checks++; if ({data_req_o, data_addr_o} !== {1'b1, 32'h1014}) begin errors++;
      $display("FAIL wrap_req5: req=%b addr=%h want 1/1014", data_req_o, data_addr_o); end
    data_gnt_i = 1'b1; tick(); data_gnt_i = 1'b0;
    check_wrap_result(4, "wrap_res4");
    tick(); idle();
    check_wrap_result(5, "wrap_res5");
    tick();
    checks++; if ({mem_result_valid_o, mem_ready_o} !== 2'b01) begin errors++;
      $display("FAIL wrap_drained: valid=%b ready=%b want 0/1", mem_result_valid_o, mem_ready_o); end
  endtask

  task automatic test_store_error();
    for (int i = 0; i < 2; i++) begin
      present(ID_WIDTH'(10 + i), 32'h20 + 32'(4 * i), (i == 0), 4'hF, 32'h1234); tick(); idle();
      data_gnt_i = 1'b1; tick(); idle();
      data_rvalid_i = 1'b1; data_err_i = 1'b1; data_rdata_i = 32'hFFFFFFFF; tick(); idle();
      checks++; if ({mem_result_valid_o, mem_result_id_o, mem_result_err_o, mem_result_rdata_o} !== {1'b1, ID_WIDTH'(10 + i), 1'b1, 32'h0}) begin
        errors++; $display("FAIL bus_err%0d: valid=%b id=%h err=%b rdata=%h want 1/%0h/1/0", i,
                           mem_result_valid_o, mem_result_id_o, mem_result_err_o, mem_result_rdata_o, 10 + i); end
      tick();
    end
  endtask

  task automatic test_reset_mid_req();
    present(1, 32'h80, 1'b0, 4'hF, 32'h0); tick(); idle();
    checks++; if (data_req_o !== 1'b1) begin errors++; $display("FAIL rst_mid_req: req=%b want 1", data_req_o); end
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    checks++; if ({data_req_o, mem_ready_o, mem_result_valid_o, data_addr_o} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL rst_mid_state: req=%b ready=%b valid=%b addr=%h want 0/1/0/0",
                         data_req_o, mem_ready_o, mem_result_valid_o, data_addr_o); end
    data_rvalid_i = 1'b1; data_rdata_i = 32'h77; tick(); idle();
    checks++; if (mem_result_valid_o !== 1'b0) begin errors++; $display("FAIL rst_stray1: valid=%b want 0", mem_result_valid_o); end
    tick();
    checks++; if ({mem_result_valid_o, mem_ready_o, data_req_o} !== 3'b010) begin errors++;
      $display("FAIL rst_stray2: valid=%b ready=%b req=%b want 0/1/0", mem_result_valid_o, mem_ready_o, data_req_o); end
  endtask

  task automatic test_random();
    logic [3:0] be_tab [8];
    int n_acc, n_res, pend_idx, outstanding, idx;
    int granted_q [$];
    bit req_pending, exp_ready, mis, rv_real, stray, v;
    logic [31:0] p_addr, p_wdata, addr, rdata;
    logic [3:0] p_be, be;
    logic p_we, we, derr;
    logic [ID_WIDTH-1:0] id;
    be_tab = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    n_acc = 0; n_res = 0; pend_idx = 0; req_pending = 0;
    p_addr = '0; p_wdata = '0; p_be = '0; p_we = 1'b0;
    idle(); rst_i = 1'b1; tick(); rst_i = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc >= 450 && n_res == n_acc && !req_pending && granted_q.size() == 0) break;
      if (mem_result_valid_o) begin
        checks++;
        if (n_res >= n_acc || !e_filled[n_res]) begin
          errors++; $display("FAIL rand_unexpected: id=%h err=%b rdata=%h with no result due", mem_result_id_o, mem_result_err_o, mem_result_rdata_o);
        end else if ({mem_result_id_o, mem_result_err_o, mem_result_rdata_o} !== {e_id[n_res], e_err[n_res], e_rdata[n_res]}) begin
          errors++; $display("FAIL rand_result%0d: id=%h err=%b rdata=%h want %h/%b/%h", n_res, mem_result_id_o,
                             mem_result_err_o, mem_result_rdata_o, e_id[n_res], e_err[n_res], e_rdata[n_res]);
        end
        n_res++;
      end
      checks++; if (data_req_o !== req_pending) begin errors++; $display("FAIL rand_req: req=%b want %b", data_req_o, req_pending); end
      if (req_pending) begin
        checks++; if ({data_addr_o, data_we_o, data_be_o, data_wdata_o} !== {p_addr, p_we, p_be, p_wdata}) begin errors++;
          $display("FAIL rand_bus: addr=%h we=%b be=%h wdata=%h want %h/%b/%h/%h", data_addr_o, data_we_o, data_be_o,
                   data_wdata_o, p_addr, p_we, p_be, p_wdata); end
      end
      v = (cyc < 400) && ($urandom_range(0, 2) != 0);
      id = ID_WIDTH'($urandom); we = 1'($urandom); be = be_tab[$urandom_range(0, 7)];
      addr = $urandom; if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      mis = model_misaligned(addr, be);
      outstanding = n_acc - n_res;
      exp_ready = !req_pending && (outstanding < DEPTH) && (!mis || outstanding == 0);
      rv_real = (granted_q.size() > 0) && ($urandom_range(0, 2) == 0);
      stray = !rv_real && outstanding == 0 && ($urandom_range(0, 9) == 0);
      rdata = $urandom; derr = ($urandom_range(0, 7) == 0);
      mem_valid_i = v; mem_id_i = id; mem_addr_i = addr; mem_we_i = we; mem_be_i = be; mem_wdata_i = $urandom;
      data_gnt_i = ($urandom_range(0, 3) == 0); data_rvalid_i = rv_real || stray; data_rdata_i = rdata; data_err_i = derr;
      #1;
      checks++; if (mem_ready_o !== exp_ready) begin errors++;
        $display("FAIL rand_ready: ready=%b want %b (addr=%h be=%h out=%0d)", mem_ready_o, exp_ready, addr, be, outstanding); end
      if (rv_real) begin
        idx = granted_q.pop_front();
        e_err[idx] = derr; e_rdata[idx] = (derr || e_we[idx]) ? 32'h0 : rdata; e_filled[idx] = 1'b1;
      end
      if (data_gnt_i && req_pending) begin granted_q.push_back(pend_idx); req_pending = 1'b0; end
      if (v && exp_ready && n_acc < MAXT) begin
        e_id[n_acc] = id; e_we[n_acc] = we;
        if (mis) begin
          e_err[n_acc] = 1'b1; e_rdata[n_acc] = 32'h0; e_filled[n_acc] = 1'b1;
        end else begin
          e_filled[n_acc] = 1'b0; req_pending = 1'b1; pend_idx = n_acc;
          p_addr = addr; p_we = we; p_be = be; p_wdata = mem_wdata_i;
        end
        n_acc++;
      end
      tick();
    end
    idle();
    checks++; if (n_res != n_acc || req_pending || granted_q.size() != 0) begin errors++;
      $display("FAIL rand_drain: results=%0d want %0d (req_pending=%b granted=%0d)", n_res, n_acc, req_pending, granted_q.size()); end
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    test_reset();
    test_aligned_load();
    test_misaligned();
    test_grant_stall();
    test_full_wrap();
    test_store_error();
    test_reset_mid_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
